// File: rtl/qa_drv_hc_issue_arb.sv
`default_nettype none
// ============================================================================
// qa_drv_hc_issue_arb : round-robin issue arbiter for the QA host channel,
//   throttled by registered almostfull, read-credit bounded, write-packet lock.
// Revision 1.0
// ============================================================================
module qa_drv_hc_issue_arb #(
  parameter int N_REQ      = 4,
  parameter int MAX_RD_OUT = 64,
  parameter int CRED_W     = $clog2(MAX_RD_OUT + 1),
  parameter int SEL_W      = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              almostfull,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ-1:0]  req_is_read,
  input  logic [N_REQ-1:0]  req_last,
  input  logic              rsp_valid,
  output logic [N_REQ-1:0]  grant,
  output logic              issue_valid,
  output logic [SEL_W-1:0]  issue_sel,
  output logic              can_issue,
  output logic [CRED_W-1:0] rd_credits,
  output logic              credit_err
);

  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_LOCKED = 1'b1;
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_RD_OUT);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             almostfull_ff;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_id;
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W:0]   scan_idx;
  logic             rd_issue;
  logic             sel_is_read;
  logic             sel_is_last;

  function automatic logic [SEL_W-1:0] inc_mod(input logic [SEL_W-1:0] x);
    if (x == SEL_W'(N_REQ - 1))
      return '0;
    return x + SEL_W'(1);
  endfunction

  assign can_issue = ~almostfull_ff;
  assign eligible  = req_valid & (~req_is_read | {N_REQ{rd_credits != '0}});

  // Rotating priority search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (scan_idx >= (SEL_W + 1)'(N_REQ))
        scan_idx = scan_idx - (SEL_W + 1)'(N_REQ);
      if (!win_found && eligible[scan_idx[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  assign sel_is_read = req_is_read[issue_sel];
  assign sel_is_last = req_last[issue_sel];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (issue_valid && !sel_is_read && !sel_is_last) state_nxt = ST_LOCKED;
      ST_LOCKED: if (issue_valid && sel_is_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A read from the lock owner is never granted while locked.
  always_comb begin
    grant     = '0;
    issue_sel = '0;
    if (can_issue) begin
      if (state == ST_LOCKED) begin
        if (req_valid[lock_id] && !req_is_read[lock_id]) begin
          grant[lock_id] = 1'b1;
          issue_sel      = lock_id;
        end
      end else if (win_found) begin
        grant[win_idx] = 1'b1;
        issue_sel      = win_idx;
      end
    end
  end

  assign issue_valid = |grant;
  assign rd_issue    = |(grant & req_is_read);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      almostfull_ff <= 1'b1;
      rr_ptr        <= '0;
      lock_id       <= '0;
    end else begin
      almostfull_ff <= almostfull;
      if (issue_valid) begin
        if (state == ST_IDLE && !sel_is_read && !sel_is_last)
          lock_id <= issue_sel;
        else if (sel_is_read || sel_is_last)
          rr_ptr <= inc_mod(issue_sel);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_credits <= CRED_MAX;
      credit_err <= 1'b0;
    end else if (rd_issue && !rsp_valid) begin
      rd_credits <= rd_credits - CRED_W'(1);
    end else if (!rd_issue && rsp_valid) begin
      if (rd_credits == CRED_MAX)
        credit_err <= 1'b1;
      else
        rd_credits <= rd_credits + CRED_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qa_drv_hc_issue_arb.sv
`default_nettype none
// Scoreboard bench for qa_drv_hc_issue_arb: a cycle-level reference model
// predicts every cycle's outputs; an independent monitor compares the DUT.
module tb_qa_drv_hc_issue_arb;
  localparam int N    = 4;
  localparam int MAXC = 2;

  logic         clk = 1'b0;
  logic         reset, almostfull, rsp_valid;
  logic [N-1:0] req_valid, req_is_read, req_last;
  logic [N-1:0] grant;
  logic         issue_valid;
  logic [1:0]   issue_sel;
  logic         can_issue;
  logic [1:0]   rd_credits;
  logic         credit_err;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         vld;
    logic [1:0]   sel;
    logic         can;
    logic [1:0]   cred;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  bit m_af, m_lock, m_err;
  int m_cred, m_ptr, m_owner;

  always #5 clk = ~clk;

  qa_drv_hc_issue_arb #(.N_REQ(N), .MAX_RD_OUT(MAXC)) dut (
    .clk(clk), .reset(reset), .almostfull(almostfull),
    .req_valid(req_valid), .req_is_read(req_is_read), .req_last(req_last),
    .rsp_valid(rsp_valid), .grant(grant), .issue_valid(issue_valid),
    .issue_sel(issue_sel), .can_issue(can_issue), .rd_credits(rd_credits),
    .credit_err(credit_err)
  );

  task automatic model_reset();
    m_af = 1; m_cred = MAXC; m_ptr = 0; m_lock = 0; m_owner = 0; m_err = 0;
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, advance the model.
  task automatic step(input logic rst_n, input logic af, input logic [N-1:0] v,
                      input logic [N-1:0] rd, input logic [N-1:0] lst, input logic rsp);
    exp_t e;
    int   g;
    int   i;
    @(negedge clk);
    reset = rst_n; almostfull = af; req_valid = v; req_is_read = rd;
    req_last = lst; rsp_valid = rsp;
    if (!rst_n) model_reset();
    g = -1;
    if (!m_af) begin
      if (m_lock) begin
        if (v[m_owner] && !rd[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (g < 0 && v[i] && (!rd[i] || m_cred > 0)) g = i;
        end
      end
    end
    e       = '0;
    if (g >= 0) e.grant[g] = 1'b1;
    e.vld   = (g >= 0);
    e.sel   = (g >= 0) ? 2'(g) : 2'd0;
    e.can   = !m_af;
    e.cred  = 2'(m_cred);
    e.err   = m_err;
    exp_q.push_back(e);
    if (rst_n) begin
      if (g >= 0 && rd[g] && !rsp) m_cred--;
      else if (!(g >= 0 && rd[g]) && rsp) begin
        if (m_cred == MAXC) m_err = 1; else m_cred++;
      end
      if (g >= 0) begin
        if (m_lock) begin
          if (lst[g]) begin m_lock = 0; m_ptr = (g + 1) % N; end
        end else if (rd[g] || lst[g]) begin
          m_ptr = (g + 1) % N;
        end else begin
          m_lock = 1; m_owner = g;
        end
      end
      m_af = af;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a.grant = grant;  mon_a.vld  = issue_valid; mon_a.sel = issue_sel;
        mon_a.can   = can_issue; mon_a.cred = rd_credits; mon_a.err = credit_err;
        n_checks++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL cyc%0d outputs: got grant=%b vld=%b sel=%0d can=%b cred=%0d err=%b, want grant=%b vld=%b sel=%0d can=%b cred=%0d err=%b",
                   cyc, mon_a.grant, mon_a.vld, mon_a.sel, mon_a.can, mon_a.cred, mon_a.err,
                   mon_e.grant, mon_e.vld, mon_e.sel, mon_e.can, mon_e.cred, mon_e.err);
        end
        cyc++;
      end
    end
  end

  initial begin
    reset = 0; almostfull = 0; rsp_valid = 0;
    req_valid = '0; req_is_read = '0; req_last = '0;
    model_reset();
    repeat (2) step(0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    // Round-robin over all-writer single-beat traffic
    repeat (6) step(1, 0, 4'b1111, 4'b0000, 4'b1111, 0);
    // almostfull throttle with one cycle latency
    repeat (3) step(1, 1, 4'b1111, 4'b0000, 4'b1111, 0);
    repeat (3) step(1, 0, 4'b1111, 4'b0000, 4'b1111, 0);
    // Requester 1 locks for a 4-beat write with a gap
    step(1, 0, 4'b0010, 4'b0000, 4'b0000, 0);
    step(1, 0, 4'b1111, 4'b0000, 4'b1101, 0);
    step(1, 0, 4'b1101, 4'b0000, 4'b1111, 0);
    step(1, 0, 4'b1111, 4'b0000, 4'b1101, 0);
    step(1, 0, 4'b1111, 4'b0000, 4'b1111, 0);
    step(1, 0, 4'b1111, 4'b0000, 4'b1111, 0);
    // Credit exhaustion; writes still flow while reads stall
    repeat (2) step(1, 0, 4'b0001, 4'b0001, 4'b0000, 0);
    step(1, 0, 4'b1001, 4'b0001, 4'b1000, 0);
    step(1, 0, 4'b1001, 4'b0001, 4'b1000, 1);
    step(1, 0, 4'b0001, 4'b0001, 4'b0000, 0);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    step(1, 0, 4'b0001, 4'b0001, 4'b0000, 1);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 1);
    repeat (2) step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    // Reset in the middle of a locked packet
    repeat (2) step(1, 0, 4'b0100, 4'b0000, 4'b0000, 0);
    step(0, 0, 4'b0100, 4'b0000, 4'b0000, 0);
    repeat (3) step(1, 0, 4'b1111, 4'b0000, 4'b1111, 0);
    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 4) == 0),
           N'($urandom), N'($urandom), N'($urandom), logic'($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    #6;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
